// File: rtl/chirp_profile_sequencer_if.sv
// Synthesiser-facing configuration and busy handshake bundle.
interface chirp_profile_sequencer_if;
   logic [31:0] opFreqLowerLimit;
   logic [31:0] opFreqUpperLimit;
   logic [31:0] opStepUp;
   logic [31:0] opStepDown;
   logic        opUpdate;
   logic        opTrigger;
   logic        ipBusy;

   modport master (
      output opFreqLowerLimit, opFreqUpperLimit, opStepUp, opStepDown,
      output opUpdate, opTrigger,
      input  ipBusy
   );

   modport slave (
      input  opFreqLowerLimit, opFreqUpperLimit, opStepUp, opStepDown,
      input  opUpdate, opTrigger,
      output ipBusy
   );
endinterface

// File: rtl/chirp_profile_sequencer.sv
// Chirp profile sequencer: rotates through a profile table, programs the
// synthesiser through an update/busy handshake and forwards armed triggers.
module chirp_profile_sequencer #(
   parameter  int unsigned PROFILES   = 4,
   parameter  int unsigned MISS_WIDTH = 16,
   localparam int unsigned IDX_W      = $clog2(PROFILES),
   localparam int unsigned NUM_W      = IDX_W + 1,
   localparam int unsigned ADDR_W     = IDX_W + 2
) (
   input  logic                      ipClk,
   input  logic                      ipReset,
   input  logic                      ipEnable,
   input  logic [NUM_W-1:0]          ipNumProfiles,
   input  logic                      ipTableWrEnable,
   input  logic [ADDR_W-1:0]         ipTableWrAddr,
   input  logic [31:0]               ipTableWrData,
   input  logic                      ipClearStatus,
   input  logic                      ipMasterTrigger,
   chirp_profile_sequencer_if.master synth,
   output logic [IDX_W-1:0]          opProfile,
   output logic                      opArmed,
   output logic [MISS_WIDTH-1:0]     opMissCount,
   output logic                      opTimeout
);
   localparam int unsigned ENTRIES = PROFILES * 4;
   localparam int unsigned TO_W    = 4;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(15);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_UPDATE, S_WAIT_START, S_WAIT_DONE, S_ARMED
   } state_t;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d, idx_wrap;
   logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
   logic                  stop_q, stop_d;
   logic [31:0]           tbl_q [ENTRIES];
   logic [31:0]           lower_q, upper_q, up_q, down_q;
   logic                  update_q, update_d;
   logic                  trigger_q, trigger_d;
   logic                  armed_q, armed_d;
   logic [IDX_W-1:0]      profile_q;
   logic [MISS_WIDTH-1:0] miss_q;
   logic                  timeout_q;
   logic [NUM_W-1:0]      num_eff, idx_inc;
   logic                  busy, accept, miss, timeout_hit;

   assign busy    = synth.ipBusy;
   assign accept  = (state_q == S_ARMED) && ipEnable && ipMasterTrigger;
   assign miss    = ipMasterTrigger && !accept;
   assign idx_inc = NUM_W'(idx_q) + NUM_W'(1);

   // Rotation length: zero behaves as one, oversize clamps to the table depth.
   always_comb begin
      num_eff = ipNumProfiles;
      if (ipNumProfiles == '0)
         num_eff = NUM_W'(1);
      else if (ipNumProfiles > NUM_W'(PROFILES))
         num_eff = NUM_W'(PROFILES);
   end

   assign idx_wrap = (idx_inc >= num_eff) ? '0 : idx_inc[IDX_W-1:0];

   // State register with the index, handshake timer and pending-disable flag.
   always_ff @(posedge ipClk) begin
      if (ipReset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         to_cnt_q <= '0;
         stop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         to_cnt_q <= to_cnt_d;
         stop_q   <= stop_d;
      end
   end

   // Next state; a disable seen mid-handshake is held until the handshake ends.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      to_cnt_d    = '0;
      stop_d      = stop_q | ~ipEnable;
      timeout_hit = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (ipEnable) state_d = S_LOAD;
         end
         S_LOAD:   state_d = S_UPDATE;
         S_UPDATE: state_d = S_WAIT_START;
         S_WAIT_START: begin
            if (busy) begin
               state_d = S_WAIT_DONE;
            end else if (to_cnt_q == TO_LAST) begin
               timeout_hit = 1'b1;
               state_d     = stop_d ? S_IDLE : S_ARMED;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         S_WAIT_DONE: begin
            if (!busy) state_d = stop_d ? S_IDLE : S_ARMED;
         end
         S_ARMED: begin
            if (!ipEnable) begin
               state_d = S_IDLE;
            end else if (ipMasterTrigger) begin
               state_d = S_LOAD;
               idx_d   = idx_wrap;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_IDLE) begin
         idx_d  = '0;
         stop_d = 1'b0;
      end
   end

   // Output decode, registered below so every pulse leaves a flop.
   always_comb begin
      update_d  = (state_d == S_UPDATE);
      armed_d   = (state_d == S_ARMED);
      trigger_d = accept;
   end

   // Output registers; configuration is captured only while in LOAD.
   always_ff @(posedge ipClk) begin
      if (ipReset) begin
         update_q  <= 1'b0;
         armed_q   <= 1'b0;
         trigger_q <= 1'b0;
         lower_q   <= '0;
         upper_q   <= '0;
         up_q      <= '0;
         down_q    <= '0;
         profile_q <= '0;
      end else begin
         update_q  <= update_d;
         armed_q   <= armed_d;
         trigger_q <= trigger_d;
         if (state_q == S_LOAD) begin
            lower_q   <= tbl_q[{idx_q, 2'd0}];
            upper_q   <= tbl_q[{idx_q, 2'd1}];
            up_q      <= tbl_q[{idx_q, 2'd2}];
            down_q    <= tbl_q[{idx_q, 2'd3}];
            profile_q <= idx_q;
         end
      end
   end

   // Profile table; a write racing a LOAD lands after the copy.
   always_ff @(posedge ipClk) begin
      if (ipReset) begin
         for (int unsigned i = 0; i < ENTRIES; i++) tbl_q[i] <= '0;
      end else if (ipTableWrEnable) begin
         tbl_q[ipTableWrAddr] <= ipTableWrData;
      end
   end

   // Status: saturating miss counter and sticky timeout; clear has priority.
   always_ff @(posedge ipClk) begin
      if (ipReset) begin
         miss_q    <= '0;
         timeout_q <= 1'b0;
      end else if (ipClearStatus) begin
         miss_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (miss && (miss_q != '1)) miss_q <= miss_q + MISS_WIDTH'(1);
         if (timeout_hit) timeout_q <= 1'b1;
      end
   end

   assign synth.opFreqLowerLimit = lower_q;
   assign synth.opFreqUpperLimit = upper_q;
   assign synth.opStepUp         = up_q;
   assign synth.opStepDown       = down_q;
   assign synth.opUpdate         = update_q;
   assign synth.opTrigger        = trigger_q;
   assign opProfile              = profile_q;
   assign opArmed                = armed_q;
   assign opMissCount            = miss_q;
   assign opTimeout              = timeout_q;
endmodule

// File: tb/tb_chirp_profile_sequencer.sv
// Scoreboard bench for chirp_profile_sequencer with a behavioural profile model.
module tb_chirp_profile_sequencer;
   localparam int unsigned PROFILES   = 4;
   localparam int unsigned MISS_WIDTH = 16;
   localparam int unsigned IDX_W      = $clog2(PROFILES);
   localparam int unsigned NUM_W      = IDX_W + 1;
   localparam int unsigned ADDR_W     = IDX_W + 2;
   localparam int          MISS_MAX   = (1 << MISS_WIDTH) - 1;

   typedef struct packed {
      logic [IDX_W-1:0]  prof;
      logic [3:0][31:0]  f;
   } load_t;

   logic                  ipClk = 1'b0;
   logic                  ipReset, ipEnable, ipTableWrEnable, ipClearStatus, ipMasterTrigger;
   logic [NUM_W-1:0]      ipNumProfiles;
   logic [ADDR_W-1:0]     ipTableWrAddr;
   logic [31:0]           ipTableWrData;
   logic [IDX_W-1:0]      opProfile;
   logic                  opArmed, opTimeout;
   logic [MISS_WIDTH-1:0] opMissCount;
   logic                  busy_auto, rnd_busy, auto_busy, man_busy;

   chirp_profile_sequencer_if synth_if();
   assign synth_if.ipBusy = busy_auto ? auto_busy : man_busy;

   chirp_profile_sequencer #(.PROFILES(PROFILES), .MISS_WIDTH(MISS_WIDTH)) dut (
      .ipClk(ipClk), .ipReset(ipReset), .ipEnable(ipEnable),
      .ipNumProfiles(ipNumProfiles), .ipTableWrEnable(ipTableWrEnable),
      .ipTableWrAddr(ipTableWrAddr), .ipTableWrData(ipTableWrData),
      .ipClearStatus(ipClearStatus), .ipMasterTrigger(ipMasterTrigger),
      .synth(synth_if), .opProfile(opProfile), .opArmed(opArmed),
      .opMissCount(opMissCount), .opTimeout(opTimeout)
   );

   initial forever #5 ipClk = ~ipClk;

   int cyc = 0;
   always @(posedge ipClk) cyc <= cyc + 1;

   // Reference model state
   logic [31:0] m_tbl [PROFILES][4];
   int          m_idx, m_miss;
   logic        m_timeout;
   load_t       exp_load [$];
   int          exp_trig [$];
   int          n_checks = 0, n_errors = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic int eff_num(int n);
      if (n == 0) return 1;
      if (n > int'(PROFILES)) return int'(PROFILES);
      return n;
   endfunction

   function automatic load_t mk_load(int p);
      load_t r;
      r.prof = IDX_W'(p);
      for (int i = 0; i < 4; i++) r.f[i] = m_tbl[p][i];
      return r;
   endfunction

   function automatic void model_miss();
      if (m_miss < MISS_MAX) m_miss++;
   endfunction

   // Monitor: pops expectations whenever the DUT emits an update or trigger.
   initial begin
      load_t e;
      int    t;
      forever begin
         @(negedge ipClk);
         if (!ipReset && synth_if.opUpdate) begin
            if (exp_load.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL unexpected_update: got opUpdate=1 expected none (cycle %0d)", cyc);
            end else begin
               e = exp_load.pop_front();
               check("load_profile", 64'(opProfile), 64'(e.prof));
               check("load_lower", 64'(synth_if.opFreqLowerLimit), 64'(e.f[0]));
               check("load_upper", 64'(synth_if.opFreqUpperLimit), 64'(e.f[1]));
               check("load_stepup", 64'(synth_if.opStepUp), 64'(e.f[2]));
               check("load_stepdown", 64'(synth_if.opStepDown), 64'(e.f[3]));
            end
         end
         if (!ipReset && synth_if.opTrigger) begin
            if (exp_trig.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL unexpected_trigger: got opTrigger=1 expected none (cycle %0d)", cyc);
            end else begin
               t = exp_trig.pop_front();
               check("trigger_cycle", 64'(cyc), 64'(t));
            end
         end
      end
   end

   // Synthesiser busy model: raises busy a few cycles after each update request.
   initial begin
      int d, l;
      auto_busy = 1'b0;
      forever begin
         @(negedge ipClk);
         if (busy_auto && synth_if.opUpdate) begin
            d = rnd_busy ? int'($urandom_range(1, 4)) : 1;
            l = rnd_busy ? int'($urandom_range(1, 5)) : 3;
            repeat (d) @(negedge ipClk);
            auto_busy = 1'b1;
            repeat (l) @(negedge ipClk);
            auto_busy = 1'b0;
         end
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic tick(int n = 1);
      repeat (n) @(negedge ipClk);
   endtask

   task automatic write_tbl(int p, int f, logic [31:0] d);
      ipTableWrEnable = 1'b1;
      ipTableWrAddr   = ADDR_W'(p * 4 + f);
      ipTableWrData   = d;
      tick();
      ipTableWrEnable = 1'b0;
      m_tbl[p][f]     = d;
   endtask

   task automatic wait_armed(string name);
      int k = 0;
      while (!opArmed && k < 80) begin tick(); k++; end
      check(name, 64'(opArmed), 64'(1));
   endtask

   task automatic wait_update(output int c);
      int k = 0;
      while (!synth_if.opUpdate && k < 40) begin tick(); k++; end
      check("update_seen", 64'(synth_if.opUpdate), 64'(1));
      c = cyc;
   endtask

   // Accepted trigger from ARMED: forwarded next cycle, next profile loaded.
   task automatic fire();
      int n;
      n = eff_num(int'(ipNumProfiles));
      ipMasterTrigger = 1'b1;
      exp_trig.push_back(cyc + 1);
      m_idx = (m_idx + 1 >= n) ? 0 : m_idx + 1;
      exp_load.push_back(mk_load(m_idx));
      tick();
      ipMasterTrigger = 1'b0;
   endtask

   task automatic start_enable();
      ipEnable = 1'b1;
      m_idx    = 0;
      exp_load.push_back(mk_load(0));
      tick();
   endtask

   task automatic miss_pulse();
      ipMasterTrigger = 1'b1;
      model_miss();
      tick();
      ipMasterTrigger = 1'b0;
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_lower"}, 64'(synth_if.opFreqLowerLimit), 64'(0));
      check({tag, "_upper"}, 64'(synth_if.opFreqUpperLimit), 64'(0));
      check({tag, "_stepup"}, 64'(synth_if.opStepUp), 64'(0));
      check({tag, "_stepdown"}, 64'(synth_if.opStepDown), 64'(0));
      check({tag, "_update"}, 64'(synth_if.opUpdate), 64'(0));
      check({tag, "_trigger"}, 64'(synth_if.opTrigger), 64'(0));
      check({tag, "_armed"}, 64'(opArmed), 64'(0));
      check({tag, "_profile"}, 64'(opProfile), 64'(0));
      check({tag, "_miss"}, 64'(opMissCount), 64'(0));
      check({tag, "_timeout"}, 64'(opTimeout), 64'(0));
   endtask

   initial begin
      int cu, ct, k, n;
      ipReset = 1'b1; ipEnable = 1'b0; ipNumProfiles = '0; ipTableWrEnable = 1'b0;
      ipTableWrAddr = '0; ipTableWrData = '0; ipClearStatus = 1'b0; ipMasterTrigger = 1'b0;
      busy_auto = 1'b0; rnd_busy = 1'b0; man_busy = 1'b0;
      for (int p = 0; p < int'(PROFILES); p++) for (int f = 0; f < 4; f++) m_tbl[p][f] = '0;
      m_idx = 0; m_miss = 0; m_timeout = 1'b0;
      tick(3);
      check_reset_outputs("reset");
      ipReset = 1'b0;
      tick();

      // Two-profile rotation with a 3-cycle busy response.
      write_tbl(0, 0, 32'h1000);
      write_tbl(1, 0, 32'h2000);
      for (int p = 0; p < 2; p++) for (int f = 1; f < 4; f++) write_tbl(p, f, $urandom);
      ipNumProfiles = NUM_W'(2);
      busy_auto = 1'b1;
      start_enable();
      wait_armed("armed_first");
      check("miss_zero", 64'(opMissCount), 64'(0));
      fire(); wait_armed("armed_p1");
      fire(); wait_armed("armed_p0");

      // Single profile still reloads; table write racing LOAD of P0.
      ipNumProfiles = NUM_W'(1);
      tick();
      fire();
      write_tbl(0, 0, 32'h5555);
      wait_armed("armed_race");
      fire(); wait_armed("armed_after_race");

      // Trigger while busy is high is dropped and counted.
      busy_auto = 1'b0;
      fire();
      wait_update(cu);
      man_busy = 1'b1;
      tick(3);
      miss_pulse();
      check("miss_waitdone", 64'(opMissCount), 64'(m_miss));
      check("armed_waitdone", 64'(opArmed), 64'(0));
      man_busy = 1'b0;
      wait_armed("armed_after_busy");

      // Busy never rises: sticky timeout after the full wait window.
      ipClearStatus = 1'b1; m_miss = 0; tick(); ipClearStatus = 1'b0;
      check("miss_cleared", 64'(opMissCount), 64'(0));
      fire();
      wait_update(cu);
      k = 0;
      while (!opTimeout && k < 40) begin tick(); k++; end
      ct = cyc;
      check("timeout_set", 64'(opTimeout), 64'(1));
      check("timeout_latency", 64'(ct - cu), 64'(17));
      check("armed_after_timeout", 64'(opArmed), 64'(1));
      m_timeout = 1'b1;
      ipClearStatus = 1'b1; m_timeout = 1'b0; tick(); ipClearStatus = 1'b0;
      check("timeout_cleared", 64'(opTimeout), 64'(m_timeout));

      // Disable during WAIT_DONE: exit deferred until busy falls, then IDLE.
      ipNumProfiles = NUM_W'(4);
      fire();
      wait_update(cu);
      man_busy = 1'b1;
      tick(3);
      ipEnable = 1'b0;
      for (int i = 0; i < 4; i++) begin tick(); check("armed_dis_busy", 64'(opArmed), 64'(0)); end
      man_busy = 1'b0;
      for (int i = 0; i < 6; i++) begin tick(); check("armed_dis_idle", 64'(opArmed), 64'(0)); end
      busy_auto = 1'b1;
      start_enable();
      wait_armed("armed_reenable");

      // Reset in the middle of WAIT_DONE.
      busy_auto = 1'b0;
      fire();
      wait_update(cu);
      man_busy = 1'b1;
      tick(3);
      miss_pulse();
      ipReset = 1'b1;
      tick();
      check_reset_outputs("midreset");
      exp_load.delete(); exp_trig.delete();
      for (int p = 0; p < int'(PROFILES); p++) for (int f = 0; f < 4; f++) m_tbl[p][f] = '0;
      m_miss = 0; m_timeout = 1'b0; m_idx = 0;
      man_busy = 1'b0; busy_auto = 1'b1;
      ipReset = 1'b0;
      exp_load.push_back(mk_load(0));
      tick();
      wait_armed("armed_post_reset");
      for (int p = 0; p < int'(PROFILES); p++) for (int f = 0; f < 4; f++) write_tbl(p, f, $urandom);

      // Randomised rotation with table/count changes and misses during LOAD.
      rnd_busy = 1'b1;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 2) == 0)
            write_tbl(int'($urandom_range(0, PROFILES - 1)), int'($urandom_range(0, 3)), $urandom);
         if ($urandom_range(0, 3) == 0) ipNumProfiles = NUM_W'($urandom_range(0, 7));
         tick(int'($urandom_range(0, 2)));
         fire();
         if ($urandom_range(0, 2) == 0) miss_pulse();
         wait_armed("armed_rand");
         check("miss_rand", 64'(opMissCount), 64'(m_miss));
         check("timeout_rand", 64'(opTimeout), 64'(m_timeout));
      end

      // Trigger coincident with disable in ARMED: disable wins, trigger counted.
      ipEnable = 1'b0;
      ipMasterTrigger = 1'b1;
      model_miss(); m_idx = 0;
      tick();
      ipMasterTrigger = 1'b0;
      check("miss_dis_trig", 64'(opMissCount), 64'(m_miss));
      check("armed_dis_trig", 64'(opArmed), 64'(0));
      tick(2);

      // Saturation of the miss counter while idle.
      n = MISS_MAX + 5;
      ipMasterTrigger = 1'b1;
      tick(n);
      ipMasterTrigger = 1'b0;
      m_miss = (m_miss + n > MISS_MAX) ? MISS_MAX : m_miss + n;
      check("miss_saturate", 64'(opMissCount), 64'(m_miss));
      ipClearStatus = 1'b1; ipMasterTrigger = 1'b1;
      m_miss = 0;
      tick();
      ipClearStatus = 1'b0; ipMasterTrigger = 1'b0;
      check("clear_wins", 64'(opMissCount), 64'(m_miss));
      miss_pulse();
      check("miss_after_clear", 64'(opMissCount), 64'(m_miss));

      tick(5);
      check("pending_loads", 64'(exp_load.size()), 64'(0));
      check("pending_triggers", 64'(exp_trig.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/chirp_profile_sequencer.md
CHIRP_PROFILE_SEQUENCER -- requirements
Module: chirp_profile_sequencer

Interface
REQ-001 SHALL have parameter PROFILES, default 4: number of chirp profile table entries (power of 2, 2..16).
REQ-002 SHALL have parameter MISS_WIDTH, default 16: width of the missed-trigger counter.
REQ-003 SHALL have ipClk  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have ipReset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ipEnable  in  1  run sequencer; low parks in IDLE.
REQ-006 SHALL have ipNumProfiles  in  log2(PROFILES)+1  profiles in rotation; 0 treated as 1; values above PROFILES clamp to PROFILES.
REQ-007 SHALL have ipTableWrEnable  in  1  table write strobe.
REQ-008 SHALL have ipTableWrAddr  in  log2(PROFILES)+2  {profile, field}; field 0=FreqLowerLimit, 1=FreqUpperLimit, 2=StepUp, 3=StepDown.
REQ-009 SHALL have ipTableWrData  in  32  table write data.
REQ-010 SHALL have ipClearStatus  in  1  one-cycle clear of opMissCount and opTimeout.
REQ-011 SHALL have ipMasterTrigger  in  1  one-cycle chirp trigger pulse.
REQ-012 SHALL have opFreqLowerLimit, opFreqUpperLimit, opStepUp, opStepDown  out  32 each  synthesiser configuration, held stable between loads.
REQ-013 SHALL have opUpdate  out  1  one-cycle synthesiser update request.
REQ-014 SHALL have ipBusy  in  1  synthesiser serial-programming busy.
REQ-015 SHALL have opTrigger  out  1  one-cycle trigger forwarded to the synthesiser trigger path.
REQ-016 SHALL have opProfile  out  log2(PROFILES)  profile currently loaded; opArmed  out  1  ready for trigger.
REQ-017 SHALL have opMissCount  out  MISS_WIDTH  saturating count of dropped triggers; opTimeout  out  1  sticky busy-handshake timeout.

Function
REQ-018 States SHALL be IDLE, LOAD, UPDATE, WAIT_START, WAIT_DONE, ARMED.
REQ-019 IDLE: outputs held; when ipEnable=1 go to LOAD with profile index 0.
REQ-020 LOAD (1 cycle): SHALL copy the four table fields of the current index into the configuration outputs; go to UPDATE.
REQ-021 UPDATE (1 cycle): opUpdate=1; go to WAIT_START.
REQ-022 WAIT_START: ipBusy=1 -> WAIT_DONE; after 16 cycles without ipBusy -> set opTimeout, go to ARMED.
REQ-023 WAIT_DONE: ipBusy=0 -> ARMED; no timeout in this state.
REQ-024 ARMED: opArmed=1; on ipMasterTrigger, opTrigger=1 in the following cycle (latency 1), index advances (wrap to 0 after ipNumProfiles-1), go to LOAD.
REQ-025 With ipNumProfiles=1, ARMED SHALL still re-run LOAD/UPDATE after each trigger (same profile).
REQ-026 ipMasterTrigger outside ARMED SHALL be dropped (no opTrigger) and increment opMissCount, saturating at all-ones.
REQ-027 ipEnable=0 in IDLE/ARMED -> IDLE next cycle, index reset to 0; in LOAD/UPDATE/WAIT_* the exit SHALL be deferred until the handshake completes (WAIT_DONE exit or timeout), then go to IDLE instead of ARMED.
REQ-028 Trigger and ipEnable falling in the same ARMED cycle: disable wins, trigger dropped and counted.
REQ-029 Table writes SHALL be accepted in any state; a write coinciding with LOAD of the same entry SHALL leave LOAD with the old value; the new value takes effect at the next load.
REQ-030 ipClearStatus coincident with a miss: clear wins (count = 0).
REQ-031 ipNumProfiles changes SHALL take effect at the next index advance; an index at or above the new count wraps to 0.

Reset
REQ-032 On ipReset: state IDLE, index 0, table entries 0, configuration outputs 0, opUpdate=0, opTrigger=0, opArmed=0, opProfile=0, opMissCount=0, opTimeout=0.
REQ-033 Reset SHALL override all other inputs in the same cycle, including mid-handshake.

Verification
REQ-034 Load 2 profiles (P0 lower=0x1000, P1 lower=0x2000), ipNumProfiles=2, enable, busy model 3 cycles high -> opUpdate pulse, opArmed; triggers alternate opFreqLowerLimit 0x1000/0x2000/0x1000, opTrigger one cycle after each trigger.
REQ-035 Trigger during WAIT_DONE -> no opTrigger, opMissCount=1; 0xFFFF misses keep the count at 0xFFFF; ipClearStatus -> 0.
REQ-036 ipBusy tied 0 -> opTimeout=1 exactly 16 cycles after WAIT_START entry, then opArmed=1.
REQ-037 ipEnable dropped during WAIT_DONE -> stays until ipBusy falls, then IDLE, opArmed never asserted, index 0.
REQ-038 ipReset asserted mid-WAIT_DONE -> all outputs at reset values next cycle; re-enable restarts at profile 0.
REQ-039 Write P0 field 0 = 0x5555 in the same cycle as LOAD of P0 -> output keeps old value; next P0 load outputs 0x5555.
